// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the 24-bit data memory. The CPU has priority, and the host is granted after STARVE_MAX contended cycles.
// Latency: a CPU grant is combinational, so the access completes in the same cycle. A host grant gives host_ack one cycle later. The CPU sees backpressure as cpu_stall.
module mem_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 24,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic [DW-1:0] cpu_dout,
  output logic          cpu_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_din,
  output logic [DW-1:0] host_dout,
  output logic          host_ack,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} ack_st_t;

  ack_st_t       ack_st_q, ack_st_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic [DW-1:0] host_dout_q, host_dout_d;
  logic          host_ack_q, host_ack_d;

  logic eligible, host_gnt, cpu_gnt, starved;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_st_q <= IDLE;
    end else begin
      ack_st_q <= ack_st_d;
    end
  end

  // Next state
  always_comb begin
    ack_st_d = ack_st_q;
    case (ack_st_q)
      IDLE:    if (host_gnt) ack_st_d = ACK;
      ACK:     ack_st_d = IDLE;
      default: ack_st_d = IDLE;
    endcase
  end

  // FSM outputs and grants. Gating with rst_n keeps the memory untouched while in reset.
  always_comb begin
    eligible = 1'b0;
    if (ack_st_q == IDLE) eligible = host_req & rst_n;
    starved  = (wait_cnt_q == 4'(STARVE_MAX));
    host_gnt = eligible & (~cpu_req | starved);
    cpu_gnt  = rst_n & cpu_req & ~host_gnt;
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (host_gnt) begin
      mem_we   = host_we;
      mem_addr = host_addr;
      mem_din  = host_din;
    end else if (cpu_gnt) begin
      mem_we   = cpu_we;
      mem_addr = cpu_addr;
      mem_din  = cpu_din;
    end
  end

  assign cpu_stall = rst_n & cpu_req & ~cpu_gnt;
  assign cpu_dout  = mem_dout;

  // The wait counter holds during the ACK cycle, which is why it uses eligible and not host_req.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (host_gnt || !host_req) begin
      wait_cnt_d = '0;
    end else if (eligible && !starved) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_comb begin
    host_dout_d = host_dout_q;
    if (host_gnt) host_dout_d = mem_dout;
    host_ack_d = host_gnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q  <= '0;
      host_dout_q <= '0;
      host_ack_q  <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      host_dout_q <= host_dout_d;
      host_ack_q  <= host_ack_d;
    end
  end

  assign host_dout = host_dout_q;
  assign host_ack  = host_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. It uses a combinational-read memory model and hand-computed expected values.
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din, cpu_dout;
  logic          cpu_stall;
  logic          host_req, host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_din, host_dout;
  logic          host_ack;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;

  logic [DW-1:0] mem [256];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_din;
  assign mem_dout = mem[mem_addr];

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_din(host_din),
    .host_dout(host_dout), .host_ack(host_ack),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Drive point: 1 ns after the rising edge. Checks follow 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_din = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_din = '0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'd1; host_req = 1; host_we = 1;
    step(); step();
    #1;
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
    n_tests++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_stall got %b exp 0", cpu_stall); end
    n_tests++; if (host_ack !== 1'b0) begin n_fail++; $display("FAIL reset_host_ack got %b exp 0", host_ack); end
    n_tests++; if (host_dout !== 24'h0) begin n_fail++; $display("FAIL reset_host_dout got %h exp 0", host_dout); end
    step();
    idle_inputs();
    rst_n = 1;
    step();
  endtask

  task automatic test_cpu_store();
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'd5; cpu_din = 24'h00ABCD;
    #1;
    n_tests++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL cpu_store_we got %b exp 1", mem_we); end
    n_tests++; if (mem_addr !== 8'd5) begin n_fail++; $display("FAIL cpu_store_addr got %0d exp 5", mem_addr); end
    n_tests++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL cpu_store_stall got %b exp 0", cpu_stall); end
    step();
    cpu_we = 0;
    #1;
    n_tests++; if (cpu_dout !== 24'h00ABCD) begin n_fail++; $display("FAIL cpu_readback got %h exp 00abcd", cpu_dout); end
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_host_read();
    host_req = 1; host_we = 0; host_addr = 8'd5;
    #1;
    n_tests++; if (mem_addr !== 8'd5) begin n_fail++; $display("FAIL host_read_addr got %0d exp 5", mem_addr); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL host_read_we got %b exp 0", mem_we); end
    step();
    host_req = 0;
    #1;
    n_tests++; if (host_ack !== 1'b1) begin n_fail++; $display("FAIL host_read_ack got %b exp 1", host_ack); end
    n_tests++; if (host_dout !== 24'h00ABCD) begin n_fail++; $display("FAIL host_read_dout got %h exp 00abcd", host_dout); end
    step();
    #1;
    n_tests++; if (host_ack !== 1'b0) begin n_fail++; $display("FAIL host_read_ack_drop got %b exp 0", host_ack); end
  endtask

  task automatic test_back_to_back();
    step();
    host_req = 1; host_we = 0; host_addr = 8'd7;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (c % 2 == 0) begin
        n_tests++; if (mem_addr !== 8'd7) begin n_fail++; $display("FAIL b2b_addr c%0d got %0d exp 7", c, mem_addr); end
        n_tests++; if (host_ack !== 1'b0) begin n_fail++; $display("FAIL b2b_ack c%0d got %b exp 0", c, host_ack); end
      end else begin
        n_tests++; if (mem_addr !== 8'd0) begin n_fail++; $display("FAIL b2b_addr c%0d got %0d exp 0", c, mem_addr); end
        n_tests++; if (host_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack c%0d got %b exp 1", c, host_ack); end
      end
      step();
    end
    host_req = 0;
    step();
  endtask

  task automatic test_starvation();
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'd5;
    host_req = 1; host_we = 0; host_addr = 8'd7;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (c == 3) begin
        n_tests++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL starve_stall c%0d got %b exp 1", c, cpu_stall); end
        n_tests++; if (mem_addr !== 8'd7) begin n_fail++; $display("FAIL starve_addr c%0d got %0d exp 7", c, mem_addr); end
      end else begin
        n_tests++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL starve_stall c%0d got %b exp 0", c, cpu_stall); end
        n_tests++; if (mem_addr !== 8'd5) begin n_fail++; $display("FAIL starve_addr c%0d got %0d exp 5", c, mem_addr); end
      end
      if (c == 4) begin
        n_tests++; if (host_ack !== 1'b1) begin n_fail++; $display("FAIL starve_ack got %b exp 1", host_ack); end
      end
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_host_write();
    host_req = 1; host_we = 1; host_addr = 8'd9; host_din = 24'h000777;
    step();
    host_req = 0;
    step();
    host_req = 1; host_we = 1; host_addr = 8'd9; host_din = 24'h123456;
    #1;
    n_tests++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL host_write_we got %b exp 1", mem_we); end
    n_tests++; if (mem_din !== 24'h123456) begin n_fail++; $display("FAIL host_write_din got %h exp 123456", mem_din); end
    step();
    host_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 8'd9;
    #1;
    n_tests++; if (cpu_dout !== 24'h123456) begin n_fail++; $display("FAIL hw_cpu_read got %h exp 123456", cpu_dout); end
    n_tests++; if (host_dout !== 24'h000777) begin n_fail++; $display("FAIL hw_old_data got %h exp 000777", host_dout); end
    n_tests++; if (host_ack !== 1'b1) begin n_fail++; $display("FAIL hw_ack got %b exp 1", host_ack); end
    n_tests++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL hw_stall got %b exp 0", cpu_stall); end
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_reset_midop();
    host_req = 1; host_we = 1; host_addr = 8'd9; host_din = 24'h000055;
    #1;
    n_tests++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL midop_grant got %b exp 1", mem_we); end
    #1;
    rst_n = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'd9; cpu_din = 24'h0000AA;
    #1;
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL midop_mem_we got %b exp 0", mem_we); end
    step();
    #1;
    n_tests++; if (host_ack !== 1'b0) begin n_fail++; $display("FAIL midop_ack got %b exp 0", host_ack); end
    n_tests++; if (host_dout !== 24'h0) begin n_fail++; $display("FAIL midop_dout got %h exp 0", host_dout); end
    n_tests++; if (dut.wait_cnt_q !== 4'd0) begin n_fail++; $display("FAIL midop_wait_cnt got %0d exp 0", dut.wait_cnt_q); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL midop_mem_we2 got %b exp 0", mem_we); end
    step();
    idle_inputs();
    rst_n = 1;
    step();
    host_req = 1; host_we = 0; host_addr = 8'd9;
    #1;
    n_tests++; if (mem_addr !== 8'd9) begin n_fail++; $display("FAIL post_reset_addr got %0d exp 9", mem_addr); end
    step();
    host_req = 0;
    #1;
    n_tests++; if (host_ack !== 1'b1) begin n_fail++; $display("FAIL post_reset_ack got %b exp 1", host_ack); end
    n_tests++; if (host_dout !== 24'h123456) begin n_fail++; $display("FAIL post_reset_dout got %h exp 123456", host_dout); end
    step();
  endtask

  initial begin
    test_reset();
    test_cpu_store();
    test_host_read();
    test_back_to_back();
    test_starvation();
    test_host_write();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
